// File: rtl/btb_update_queue.sv
// btb_update_queue: in-order buffer between retire and the BTB retire write
// port. Resolved branches are queued and driven one per cycle through a
// registered output stage; an update is replayed while the BTB is busy with
// a fetch1 speculative write. Overflowing updates are dropped and counted.
module btb_update_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rt_valid_i,
  input  logic [63:0]   rt_brpc_i,
  input  logic          rt_brdir_i,
  input  logic [63:0]   rt_tar_i,
  input  logic          sp_we_i,
  output logic          btb_rt_we_o,
  output logic [63:0]   btb_rt_brpc_o,
  output logic          btb_rt_brdir_o,
  output logic [63:0]   btb_taken_addr_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic [15:0]   drop_cnt_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // FIFO storage, one array per field
  logic [63:0]   mem_pc  [DEPTH];
  logic          mem_dir [DEPTH];
  logic [63:0]   mem_tar [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   drop_cnt;

  // output stage
  logic          or_we;
  logic [63:0]   or_pc;
  logic          or_dir;
  logic [63:0]   or_tar;

  logic          acc;
  logic          refill;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          bypass;
  logic          push;
  logic          drop;

  // Control decode: acceptance, refill source selection, push/drop decision.
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  always_comb begin
    acc        = or_we && !sp_we_i;
    refill     = !or_we || acc;
    fifo_empty = (count == '0);
    fifo_full  = (count == DEPTH_C);
    pop        = refill && !fifo_empty;
    bypass     = refill && fifo_empty && rt_valid_i;
    push       = rt_valid_i && !bypass && (!fifo_full || pop);
    drop       = rt_valid_i && !bypass && !push;
  end

  // FIFO entry write; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc[wr_ptr]  <= rt_brpc_i;
      mem_dir[wr_ptr] <= rt_brdir_i;
      mem_tar[wr_ptr] <= rt_tar_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Output stage: hold on replay, otherwise refill from FIFO head, then bypass
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      or_we  <= 1'b0;
      or_pc  <= '0;
      or_dir <= 1'b0;
      or_tar <= '0;
    end else if (refill) begin
      if (pop) begin
        or_we  <= 1'b1;
        or_pc  <= mem_pc[rd_ptr];
        or_dir <= mem_dir[rd_ptr];
        or_tar <= mem_tar[rd_ptr];
      end else if (rt_valid_i) begin
        or_we  <= 1'b1;
        or_pc  <= rt_brpc_i;
        or_dir <= rt_brdir_i;
        or_tar <= rt_tar_i;
      end else begin
        or_we  <= 1'b0;
      end
    end
  end

  // Saturating count of updates lost to overflow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign btb_rt_we_o      = or_we;
  assign btb_rt_brpc_o    = or_pc;
  assign btb_rt_brdir_o   = or_dir;
  assign btb_taken_addr_o = or_tar;
  assign count_o          = count;
  assign full_o           = fifo_full;
  assign drop_cnt_o       = drop_cnt;

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_btb_update_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clock;
  logic          reset_n;
  logic          rt_valid_i;
  logic [63:0]   rt_brpc_i;
  logic          rt_brdir_i;
  logic [63:0]   rt_tar_i;
  logic          sp_we_i;
  logic          btb_rt_we_o;
  logic [63:0]   btb_rt_brpc_o;
  logic          btb_rt_brdir_o;
  logic [63:0]   btb_taken_addr_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic [15:0]   drop_cnt_o;

  btb_update_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rt_valid_i       (rt_valid_i),
    .rt_brpc_i        (rt_brpc_i),
    .rt_brdir_i       (rt_brdir_i),
    .rt_tar_i         (rt_tar_i),
    .sp_we_i          (sp_we_i),
    .btb_rt_we_o      (btb_rt_we_o),
    .btb_rt_brpc_o    (btb_rt_brpc_o),
    .btb_rt_brdir_o   (btb_rt_brdir_o),
    .btb_taken_addr_o (btb_taken_addr_o),
    .count_o          (count_o),
    .full_o           (full_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: the output slot plus a plain queue of waiting updates
  typedef struct {
    logic [63:0] pc;
    logic        dir;
    logic [63:0] tar;
  } upd_t;

  upd_t mq[$];
  upd_t m_or;
  bit   m_we;
  int   m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we   = 1'b0;
    m_or   = '{pc: '0, dir: 1'b0, tar: '0};
    m_drop = 0;
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic model_step();
    upd_t in;
    in = '{pc: rt_brpc_i, dir: rt_brdir_i, tar: rt_tar_i};
    if (!m_we || !sp_we_i) begin
      if (mq.size() > 0) begin
        m_or = mq.pop_front();
        m_we = 1'b1;
        if (rt_valid_i) mq.push_back(in);
      end else if (rt_valid_i) begin
        m_or = in;
        m_we = 1'b1;
      end else begin
        m_we = 1'b0;
      end
    end else if (rt_valid_i) begin
      if (mq.size() < DEPTH) mq.push_back(in);
      else if (m_drop < 65535) m_drop++;
    end
  endtask

  // Cycle-by-cycle comparison against the model, sampled on the falling edge
  always @(negedge clock) begin
    if (chk_en) begin
      chk("we", 64'(btb_rt_we_o), 64'(m_we));
      if (m_we) begin
        chk("pc", btb_rt_brpc_o, m_or.pc);
        chk("dir", 64'(btb_rt_brdir_o), 64'(m_or.dir));
        chk("tar", btb_taken_addr_o, m_or.tar);
      end
      chk("count", 64'(count_o), 64'(mq.size()));
      chk("full", 64'(full_o), 64'(mq.size() == DEPTH));
      chk("drop", 64'(drop_cnt_o), 64'(m_drop));
    end
  end

  // Present inputs for one cycle; returns 1ns after the edge
  task automatic cyc(input bit v, input logic [63:0] pc, input bit dir,
                     input logic [63:0] tar, input bit sp);
    rt_valid_i = v;
    rt_brpc_i  = pc;
    rt_brdir_i = dir;
    rt_tar_i   = tar;
    sp_we_i    = sp;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    model_reset();
    rt_valid_i = 1'b0;
    sp_we_i    = 1'b0;
    #10;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    int pv;
    int ps;
    reset_n    = 1'b0;
    rt_valid_i = 1'b0;
    rt_brpc_i  = '0;
    rt_brdir_i = 1'b0;
    rt_tar_i   = '0;
    sp_we_i    = 1'b0;
    model_reset();
    #3;
    chk("rst_we", 64'(btb_rt_we_o), 64'd0);
    chk("rst_pc", btb_rt_brpc_o, 64'd0);
    chk("rst_tar", btb_taken_addr_o, 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    #9;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_en = 1'b1;

    // Bypass from an idle queue
    cyc(1, 64'h1000, 1, 64'h2000, 0);
    chk("byp_we", 64'(btb_rt_we_o), 64'd1);
    chk("byp_pc", btb_rt_brpc_o, 64'h1000);
    chk("byp_dir", 64'(btb_rt_brdir_o), 64'd1);
    chk("byp_tar", btb_taken_addr_o, 64'h2000);
    chk("byp_cnt", 64'(count_o), 64'd0);
    cyc(0, 64'h0, 0, 64'h0, 0);
    chk("byp_we_off", 64'(btb_rt_we_o), 64'd0);

    // Replay: three speculative-write cycles hold the update
    cyc(1, 64'h1000, 1, 64'h2000, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 64'h0, 0, 64'h0, 1);
      chk("rep_we", 64'(btb_rt_we_o), 64'd1);
      chk("rep_pc", btb_rt_brpc_o, 64'h1000);
    end
    cyc(0, 64'h0, 0, 64'h0, 0);
    chk("rep_we_off", 64'(btb_rt_we_o), 64'd0);

    // Burst ordering behind a held output
    cyc(1, 64'h100, 0, 64'h900, 0);
    cyc(1, 64'h104, 1, 64'h904, 1);
    cyc(1, 64'h108, 0, 64'h908, 1);
    cyc(1, 64'h10C, 1, 64'h90C, 1);
    chk("burst_cnt", 64'(count_o), 64'd3);
    cyc(0, 64'h0, 0, 64'h0, 1);
    chk("burst_hold", btb_rt_brpc_o, 64'h100);
    cyc(0, 64'h0, 0, 64'h0, 0);
    chk("burst_1", btb_rt_brpc_o, 64'h104);
    cyc(0, 64'h0, 0, 64'h0, 0);
    chk("burst_2", btb_rt_brpc_o, 64'h108);
    cyc(0, 64'h0, 0, 64'h0, 0);
    chk("burst_3", btb_rt_brpc_o, 64'h10C);
    cyc(0, 64'h0, 0, 64'h0, 0);
    chk("burst_end", 64'(btb_rt_we_o), 64'd0);

    // Overflow, then a push into a full FIFO alongside a pop
    do_reset();
    for (int k = 1; k <= 10; k++) cyc(1, 64'(k), k[0], 64'(k + 100), 1);
    chk("ovf_full", 64'(full_o), 64'd1);
    chk("ovf_cnt", 64'(count_o), 64'd8);
    chk("ovf_drop", 64'(drop_cnt_o), 64'd1);
    chk("ovf_or", btb_rt_brpc_o, 64'd1);
    cyc(1, 64'd11, 1, 64'd111, 0);
    chk("fp_pc", btb_rt_brpc_o, 64'd2);
    chk("fp_cnt", 64'(count_o), 64'd8);
    chk("fp_drop", 64'(drop_cnt_o), 64'd1);
    for (int k = 3; k <= 9; k++) begin
      cyc(0, 64'h0, 0, 64'h0, 0);
      chk("drain_pc", btb_rt_brpc_o, 64'(k));
    end
    cyc(0, 64'h0, 0, 64'h0, 0);
    chk("drain_wrap", btb_rt_brpc_o, 64'd11);
    cyc(0, 64'h0, 0, 64'h0, 0);
    chk("drain_end", 64'(btb_rt_we_o), 64'd0);

    // Asynchronous reset with work pending
    for (int k = 1; k <= 6; k++) cyc(1, 64'(k + 32), 1, 64'(k), 1);
    chk("pre_rst_cnt", 64'(count_o), 64'd5);
    chk_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we", 64'(btb_rt_we_o), 64'd0);
    chk("arst_pc", btb_rt_brpc_o, 64'd0);
    chk("arst_tar", btb_taken_addr_o, 64'd0);
    chk("arst_cnt", 64'(count_o), 64'd0);
    chk("arst_full", 64'(full_o), 64'd0);
    chk("arst_drop", 64'(drop_cnt_o), 64'd0);
    model_reset();
    rt_valid_i = 1'b0;
    sp_we_i    = 1'b0;
    #10;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    cyc(1, 64'hABCD, 0, 64'hBEEF, 0);
    chk("post_rst_we", 64'(btb_rt_we_o), 64'd1);
    chk("post_rst_pc", btb_rt_brpc_o, 64'hABCD);

    // Randomized traffic with shifting valid / speculative-write densities
    pv = 50;
    ps = 30;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        pv = int'($urandom_range(10, 100));
        ps = int'($urandom_range(0, 90));
      end
      cyc($urandom_range(0, 99) < pv, {$urandom, $urandom}, 1'($urandom),
          {$urandom, $urandom}, $urandom_range(0, 99) < ps);
    end

    @(negedge clock);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Retire-side producer for the BTB way's commit-update port. Buffers resolved branch outcomes from retire in an in-order FIFO and drives one registered update per cycle onto the BTB retire write interface (`btb_rt_we`, `btb_rt_brdir`, `btb_rt_brpc`, `taken_addr`). The BTB drops a retire write in any cycle where a fetch1 speculative write is active, so this block holds and replays the update until it lands in a cycle without a speculative write. Retire never stalls on this block; on overflow, updates are dropped and counted.

## Interface
- `DEPTH`, default 8: number of FIFO entries (power of 2, ≥2).
- `AW`, default 3: log2(`DEPTH`).
- `clock`  in  1  core clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rt_valid_i`  in  1  retire presents a resolved branch this cycle.
- `rt_brpc_i`  in  64  bundle PC of the resolved branch.
- `rt_brdir_i`  in  1  resolved direction (1 = taken).
- `rt_tar_i`  in  64  resolved taken address.
- `sp_we_i`  in  1  fetch1 speculative BTB write active this cycle.
- `btb_rt_we_o`  out  1  update valid to BTB.
- `btb_rt_brpc_o`  out  64  update PC.
- `btb_rt_brdir_o`  out  1  update direction.
- `btb_taken_addr_o`  out  64  update target.
- `count_o`  out  AW+1  FIFO occupancy, excluding the output stage.
- `full_o`  out  1  `count_o == DEPTH`.
- `drop_cnt_o`  out  16  saturating count of dropped updates.

## Operation
- Storage: `DEPTH`-entry circular FIFO of {pc[63:0], dir, tar[63:0]}, plus one output register (OR) that drives all `btb_*_o` ports.
- Pointers: `wr_ptr` and `rd_ptr` are AW bits each and wrap modulo `DEPTH`. Count is kept separately in AW+1 bits.
- Accept: an update is accepted (`acc`) when `btb_rt_we_o && !sp_we_i`. When `btb_rt_we_o && sp_we_i`, the OR holds all of its values unchanged (replay).
- OR refill occurs when the OR is empty or `acc` is true:
  - FIFO non-empty: pop the head into the OR (`pop`).
  - Else, `rt_valid_i`: load the input directly into the OR (bypass; the entry does not touch the FIFO).
  - Else: `btb_rt_we_o` goes to 0.
- Enqueue happens when `rt_valid_i` is true and the input is not bypassed:
  - Push if `count < DEPTH`, or if `pop` occurs in the same cycle.
  - Otherwise drop the update and increment `drop_cnt_o`, saturating at 16'hFFFF.
- Ordering: updates reach the BTB in strict retire order. Bypass is allowed only when the FIFO is empty.
- Simultaneous push and pop: count unchanged, both pointers advance.
- A bypass never coexists with a push in the same cycle, because retire delivers at most one update per cycle.
- No flush input: retire outcomes are architectural and are always drained.

## Timing
- Reset (async, immediate), all outputs:
  - `btb_rt_we_o` = 0
  - `btb_rt_brpc_o` = 0
  - `btb_rt_brdir_o` = 0
  - `btb_taken_addr_o` = 0
  - `count_o` = 0
  - `full_o` = 0
  - `drop_cnt_o` = 0
  - Pointers = 0
- FIFO contents need no reset.
- Reset mid-operation discards all pending updates. No partial output survives reset.
- Latency:
  - Empty queue, `rt_valid_i` at cycle N → `btb_rt_we_o` = 1 at cycle N+1 (bypass).
  - FIFO entry at head with OR accepting at cycle N → on OR at N+1.
- Throughput: one update per cycle when `sp_we_i` stays low.
- Each `sp_we_i` cycle while `btb_rt_we_o` = 1 adds one replay cycle.
- Full boundary:
  - `count == DEPTH` with `pop` in the same cycle: the input is pushed, no drop.
  - `count == DEPTH` without `pop`: the input is dropped.
- `full_o` and `count_o` are registered and reflect state after the previous edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Bypass: idle queue, `rt_valid_i`=1, pc=64'h1000, dir=1, tar=64'h2000 at cycle 0 → cycle 1: `btb_rt_we_o`=1 with pc 64'h1000, dir 1, target 64'h2000. Cycle 2: `btb_rt_we_o`=0. `count_o` stays 0 throughout.
- Replay: same stimulus, with `sp_we_i`=1 in cycles 1–3 → outputs held unchanged in cycles 1–4. `btb_rt_we_o` drops to 0 in cycle 5.
- Ordering/burst: pcs 64'h100, 64'h104, 64'h108, 64'h10C on consecutive cycles, `sp_we_i` held high for cycles 1–4 → OR shows 64'h100 through cycle 5, then 64'h104, 64'h108, 64'h10C on consecutive cycles. Peak `count_o`=3.
- Overflow: `DEPTH`=8, `sp_we_i` held high, 10 consecutive `rt_valid_i` pulses → first pulse goes to the OR, next 8 fill the FIFO (`full_o`=1), tenth is dropped. `drop_cnt_o`=1, and draining yields pcs 1–9 in order.
- Full with simultaneous pop: FIFO full, `sp_we_i` low, `rt_valid_i`=1 → no drop, `count_o` stays 8, and the pointer wraps past `DEPTH`-1 correctly.
- Async reset with 5 entries queued and `btb_rt_we_o`=1 → all outputs 0 immediately. After release, the first new update appears 1 cycle after `rt_valid_i`.
